// File: rtl/wb_sram_ctrl.sv
// wb_sram_ctrl: Wishbone B4 pipelined slave driving an asynchronous 16-bit SRAM.
// Each accepted request becomes one timed SRAM access:
//   - reads hold oe_n low for RD_WAIT cycles;
//   - writes hold we_n low for WR_WAIT cycles, followed by one hold cycle.
// Optional feature macro: SRAM_CTRL_TURNAROUND_EN inserts one dead cycle (TURN)
// after every access.
module wb_sram_ctrl #(
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned RD_WAIT    = 2,
  parameter int unsigned WR_WAIT    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [15:0]           wb_dat_i,
  input  logic [1:0]            wb_sel_i,
  output logic [15:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_stall_o,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [15:0]           sram_dq_i,
  output logic [15:0]           sram_dq_o,
  output logic                  sram_dq_oe,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic                  sram_lb_n,
  output logic                  sram_ub_n
);

  localparam int unsigned MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int unsigned CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WRITE = 3'd2,
`ifdef SRAM_CTRL_TURNAROUND_EN
    S_WHOLD = 3'd3,
    S_TURN  = 3'd4
`else
    S_WHOLD = 3'd3
`endif
  } state_t;

  // State entered at the edge that completes an access
`ifdef SRAM_CTRL_TURNAROUND_EN
  localparam state_t DONE_ST = S_TURN;
`else
  localparam state_t DONE_ST = S_IDLE;
`endif

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [1:0]              sel_q;
  logic                    ack_q;
  logic [15:0]             rdat_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [15:0]             dq_o_q;
  logic                    dq_oe_q;
  logic                    ce_n_q;
  logic                    oe_n_q;
  logic                    we_n_q;
  logic                    lb_n_q;
  logic                    ub_n_q;

  logic                    req_c;
  logic                    cnt_zero_c;
  logic [15:0]             rd_mask_c;

  // Request qualification and byte-lane masking of read data
  assign req_c      = wb_cyc_i & wb_stb_i & (state_q == S_IDLE);
  assign cnt_zero_c = (cnt_q == '0);
  assign rd_mask_c  = {sram_dq_i[15:8] & {8{sel_q[1]}}, sram_dq_i[7:0] & {8{sel_q[0]}}};

  // Access sequencer: all bus and SRAM outputs are registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= 2'b00;
      ack_q   <= 1'b0;
      rdat_q  <= 16'h0000;
      addr_q  <= '0;
      dq_o_q  <= 16'h0000;
      dq_oe_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_c) begin
            addr_q <= wb_adr_i;
            sel_q  <= wb_sel_i;
            ce_n_q <= 1'b0;
            lb_n_q <= ~wb_sel_i[0];
            ub_n_q <= ~wb_sel_i[1];
            if (wb_we_i) begin
              dq_o_q  <= wb_dat_i;
              dq_oe_q <= 1'b1;
              we_n_q  <= 1'b0;
              cnt_q   <= CNT_W'(WR_WAIT - 1);
              state_q <= S_WRITE;
            end else begin
              oe_n_q  <= 1'b0;
              cnt_q   <= CNT_W'(RD_WAIT - 1);
              state_q <= S_READ;
            end
          end
        end
        S_READ: begin
          if (cnt_zero_c) begin
            rdat_q  <= rd_mask_c;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            ack_q   <= wb_cyc_i;
            state_q <= DONE_ST;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_WRITE: begin
          // we_n rises first; address and data remain driven through WHOLD
          if (cnt_zero_c) begin
            we_n_q  <= 1'b1;
            state_q <= S_WHOLD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_WHOLD: begin
          ce_n_q  <= 1'b1;
          lb_n_q  <= 1'b1;
          ub_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
          ack_q   <= wb_cyc_i;
          state_q <= DONE_ST;
        end
`ifdef SRAM_CTRL_TURNAROUND_EN
        S_TURN: begin
          state_q <= S_IDLE;
        end
`endif
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign wb_stall_o = (state_q != S_IDLE);
  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = rdat_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_lb_n  = lb_n_q;
  assign sram_ub_n  = ub_n_q;

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Bench for wb_sram_ctrl: a behavioural async SRAM plus a word-level reference
// memory; directed cases followed by randomized single transactions.
`timescale 1ns/1ps
module tb_wb_sram_ctrl;

  localparam int unsigned AW   = 18;
  localparam int unsigned RD_W = 3;
  localparam int unsigned WR_W = 2;
`ifdef SRAM_CTRL_TURNAROUND_EN
  localparam int unsigned TURN = 1;
`else
  localparam int unsigned TURN = 0;
`endif
  // Packed reset image of the outputs: only the five active-low strobes are 1
  localparam logic [63:0] RST_VAL = 64'h1F;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_cyc_i, wb_stb_i, wb_we_i;
  logic [AW-1:0] wb_adr_i;
  logic [15:0]   wb_dat_i;
  logic [1:0]    wb_sel_i;
  logic [15:0]   wb_dat_o;
  logic          wb_ack_o, wb_stall_o;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_i, sram_dq_o;
  logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

  int total = 0;
  int bad   = 0;

  logic [15:0]   sram_mem [logic [AW-1:0]];
  logic [15:0]   ref_mem  [logic [AW-1:0]];
  logic [15:0]   mdl_w;
  logic [AW-1:0] pool [6] = '{18'h00012, 18'h00020, 18'h3FFFF, 18'h00000, 18'h1ABCD, 18'h2A5A5};

  always #5 clk = ~clk;

  wb_sram_ctrl #(.ADDR_WIDTH(AW), .RD_WAIT(RD_W), .WR_WAIT(WR_W)) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_stall_o(wb_stall_o),
    .sram_addr(sram_addr), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
  );

  function automatic logic [15:0] sram_rd(input logic [AW-1:0] a);
    return (sram_mem.exists(a) != 0) ? sram_mem[a] : 16'h0000;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [AW-1:0] a);
    return (ref_mem.exists(a) != 0) ? ref_mem[a] : 16'h0000;
  endfunction

  function automatic logic [63:0] outs();
    return 64'({wb_ack_o, wb_stall_o, wb_dat_o, sram_addr, sram_dq_o, sram_dq_oe,
                sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n});
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Async SRAM model: writes selected lanes while we_n/ce_n low, drives data while oe_n/ce_n low
  always @(negedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      mdl_w = sram_rd(sram_addr);
      if (!sram_lb_n) mdl_w[7:0]  = sram_dq_o[7:0];
      if (!sram_ub_n) mdl_w[15:8] = sram_dq_o[15:8];
      sram_mem[sram_addr] = mdl_w;
    end
    if (!sram_ce_n && !sram_oe_n) sram_dq_i = sram_rd(sram_addr);
    else                          sram_dq_i = 16'($urandom);
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (wb_stall_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", 64'(n < 20), 64'(1));
  endtask

  // One transaction, checked against latency, strobe width, stall and data rules
  task automatic access(input logic we, input logic [AW-1:0] adr, input logic [15:0] dat,
                        input logic [1:0] sel, input bit abort);
    int exp_lat, acks, first_ack, strobe_lo, stall_hi, bad_addr;
    logic [15:0] exp_rd, got_rd, pre_dat, merged;
    exp_lat = we ? int'(WR_W) + 1 : int'(RD_W);
    exp_rd  = ref_rd(adr) & {{8{sel[1]}}, {8{sel[0]}}};
    wait_idle();
    pre_dat  = wb_dat_o;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
    @(posedge clk);
    @(negedge clk);
    wb_stb_i = 1'b0;
    if (abort) wb_cyc_i = 1'b0;
    acks = 0; first_ack = -1; strobe_lo = 0; stall_hi = 0; bad_addr = 0; got_rd = 16'h0;
    for (int k = 0; k <= exp_lat + 2; k++) begin
      if (k > 0) @(negedge clk);
      if (wb_ack_o) begin
        acks++;
        if (first_ack < 0) begin
          first_ack = k;
          got_rd    = wb_dat_o;
        end
      end
      if (we ? !sram_we_n : !sram_oe_n) strobe_lo++;
      if (wb_stall_o) stall_hi++;
      if (!sram_ce_n && (sram_addr !== adr || sram_lb_n !== ~sel[0] || sram_ub_n !== ~sel[1]))
        bad_addr++;
    end
    wb_cyc_i = 1'b0;
    check(we ? "we_n_low_cycles" : "oe_n_low_cycles", 64'(strobe_lo), 64'(we ? WR_W : RD_W));
    check("stall_cycles", 64'(stall_hi), 64'(exp_lat + int'(TURN)));
    check("addr_lane_stable", 64'(bad_addr), 64'(0));
    if (abort) begin
      check("abort_no_ack", 64'(acks), 64'(0));
    end else begin
      check("ack_count", 64'(acks), 64'(1));
      check("ack_latency", 64'(first_ack), 64'(exp_lat));
      if (!we) check("rd_data", 64'(got_rd), 64'(exp_rd));
    end
    if (we) begin
      merged = ref_rd(adr);
      if (sel[0]) merged[7:0]  = dat[7:0];
      if (sel[1]) merged[15:8] = dat[15:8];
      ref_mem[adr] = merged;
      check("sram_word", 64'(sram_rd(adr)), 64'(merged));
      check("dat_o_unchanged", 64'(wb_dat_o), 64'(pre_dat));
    end
  endtask

  // Two requests with stb held high: checks issue period, ack count and dead cycles
  task automatic burst(input logic we, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic [15:0] d1, input logic [15:0] d2);
    int n_acc, acks, cyc_cnt, dead, data_bad, acc0, acc1, exp_period;
    bit will;
    logic [15:0] exp_rd;
    exp_period = we ? int'(WR_W) + 2 + int'(TURN) : int'(RD_W) + 1 + int'(TURN);
    wait_idle();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = a1;   wb_dat_i = d1;   wb_sel_i = 2'b11;
    n_acc = 0; acks = 0; cyc_cnt = 0; dead = 0; data_bad = 0; acc0 = 0; acc1 = 0;
    for (int c = 0; c < 30; c++) begin
      will = wb_stb_i && !wb_stall_o;
      @(posedge clk);
      cyc_cnt++;
      if (will) begin
        if (n_acc == 0) acc0 = cyc_cnt;
        else            acc1 = cyc_cnt;
        n_acc++;
      end
      @(negedge clk);
      if (will) begin
        if (n_acc == 1) begin
          wb_adr_i = a2;
          wb_dat_i = d2;
        end else begin
          wb_stb_i = 1'b0;
        end
      end
      if (n_acc == 1 && sram_ce_n && !sram_dq_oe) dead++;
      if (wb_ack_o) begin
        acks++;
        exp_rd = ref_rd(acks == 1 ? a1 : a2);
        if (!we && wb_dat_o !== exp_rd) data_bad++;
      end
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    check("b2b_accepts", 64'(n_acc), 64'(2));
    check("b2b_period", 64'(acc1 - acc0), 64'(exp_period));
    check("b2b_acks", 64'(acks), 64'(2));
    check("b2b_dead_cycles", 64'(dead), 64'(1 + TURN));
    if (!we) check("b2b_rd_data", 64'(data_bad), 64'(0));
    if (we) begin
      ref_mem[a1] = d1;
      ref_mem[a2] = d2;
      check("b2b_wr_word1", 64'(sram_rd(a1)), 64'(d1));
      check("b2b_wr_word2", 64'(sram_rd(a2)), 64'(d2));
    end
  endtask

  // Assert reset between edges during an access; outputs must reset with no clock
  task automatic reset_mid(input logic we);
    int acks;
    wait_idle();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = 18'h003A5; wb_dat_i = 16'hFFFF; wb_sel_i = 2'b11;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check(we ? "rst_mid_write" : "rst_mid_read", outs(), RST_VAL);
    wb_stb_i = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (wb_ack_o) acks++;
    end
    wb_cyc_i = 1'b0;
    check("rst_no_ack", 64'(acks), 64'(0));
  endtask

  initial begin
    logic          r_we;
    logic [15:0]   r_dat;
    logic [1:0]    r_sel;
    bit            r_ab;
    logic [AW-1:0] r_adr;
    rst = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0;   wb_dat_i = 16'h0; wb_sel_i = 2'b00;
    #1 rst = 1'b1;
    #1 check("reset_values", outs(), RST_VAL);
    #20 rst = 1'b0;

    access(1'b1, 18'h00012, 16'hBEEF, 2'b11, 1'b0);
    access(1'b0, 18'h00012, 16'h0000, 2'b11, 1'b0);
    access(1'b1, 18'h00012, 16'h1234, 2'b01, 1'b0);
    check("byte_lane_word", 64'(sram_rd(18'h00012)), 64'(16'hBE34));
    access(1'b0, 18'h00012, 16'h0000, 2'b10, 1'b0);
    access(1'b0, 18'h00012, 16'h0000, 2'b00, 1'b0);
    access(1'b1, 18'h00020, 16'hA5A5, 2'b11, 1'b1);
    check("abort_word", 64'(sram_rd(18'h00020)), 64'(16'hA5A5));
    burst(1'b0, 18'h00012, 18'h00020, 16'h0, 16'h0);
    burst(1'b1, 18'h3FFFF, 18'h00000, 16'h5A5A, 16'hC3C3);
    access(1'b0, 18'h3FFFF, 16'h0000, 2'b11, 1'b0);
    reset_mid(1'b0);
    reset_mid(1'b1);

    for (int i = 0; i < 40; i++) begin
      r_adr = pool[$urandom_range(0, 5)];
      r_we  = 1'($urandom_range(0, 1));
      r_dat = 16'($urandom);
      r_sel = 2'($urandom);
      r_ab  = ($urandom_range(0, 9) == 0);
      access(r_we, r_adr, r_dat, r_sel, r_ab);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
